ct_vfalu_wb_pipe_gen: RTL and testbench
=======================================

# ct_vfalu_wb_pipe_gen

Parametrised result-collection pipeline for a VFALU execution pipe. It tracks every issued operation from EX1 to its result stage EX`LAT` and selects the owning sub-unit's data and exception flags at that stage. It registers writeback data, tag and flags, and accumulates sticky exception flags. It sits between the per-pipe functional units (convert, add/compare, special-permute) and the register-file writeback/forwarding network. It generalises the fixed three-unit, EX3-result datapath to any unit count, result latency and data width, and adds flush, tag tracking and a protocol checker.

## Interface
Parameters:
- `DATA_W`, 64, result/mfvr data width
- `EREG_W`, 5, exception flag width (NV, DZ, OF, UF, NX)
- `NUM_UNIT`, 3, number of functional units (2..8)
- `LAT`, 3, stage index at which unit results are valid (2..6)
- `TAG_W`, 7, destination tag width

Ports (all synchronous to `forever_cpuclk`):
- `forever_cpuclk` in 1: the single clock.
- `cpurst_b` in 1: reset, synchronous, active-low.
- `ex1_vld` in 1: an operation is issued in EX1 this cycle.
- `ex1_sel` in NUM_UNIT: one-hot owning unit.
- `ex1_tag` in TAG_W: destination tag.
- `flush` in 1: kills all in-flight operations, including one in EX1 this cycle.
- `unit_mfvr_data` in NUM_UNIT*DATA_W: per-unit EX1 move-from-vector data.
- `unit_r_vld` in NUM_UNIT: per-unit result valid at EX`LAT`.
- `unit_result` in NUM_UNIT*DATA_W: per-unit result at EX`LAT`.
- `unit_ereg_vld` in NUM_UNIT: per-unit flags valid at EX`LAT`.
- `unit_ereg` in NUM_UNIT*EREG_W: per-unit flags at EX`LAT`.
- `fflags_clr` in 1: clears the sticky flags.
- `ex1_mfvr_data` out DATA_W: combinational AND-OR of `unit_mfvr_data` by `ex1_sel`.
- `wb_vld` out 1: registered writeback valid.
- `wb_tag` out TAG_W: registered writeback tag.
- `wb_data` out DATA_W: registered writeback data.
- `wb_ereg` out EREG_W: registered writeback flags.
- `fflags` out EREG_W: sticky OR of written-back flags.
- `proto_err` out 1: sticky protocol error.

## Operation
- Tracking shift register of depth LAT-1 holding {vld, sel, tag}.
  - Stage 2 loads the EX1 values.
  - Stage k+1 loads stage k each cycle.
  - There is no stall; the pipe always advances.
- `flush` clears every tracked vld on the next edge. An op issued in the same cycle as `flush` is also dropped.
- At EX`LAT`, with tracked vld=1:
  - `wb_data` = AND-OR of `unit_result` by tracked sel.
  - `wb_ereg` = AND-OR of `unit_ereg` gated by `unit_ereg_vld`. It is 0 if the owning unit's `unit_ereg_vld`=0.
  - `wb_tag` = tracked tag.
- When tracked vld=0, `wb_vld`=0 and `wb_data`/`wb_tag`/`wb_ereg` hold their previous values.
- `fflags` is updated on each `wb_vld` cycle: `fflags` <= `fflags` | `wb_ereg`.
- `fflags_clr` has priority over the OR in the same cycle. The clear applies first, then the new flags are ORed in, so a flag arriving in the clear cycle survives.
- `proto_err` sets (sticky until reset) on either condition:
  - `unit_r_vld` != (tracked vld ? tracked sel : 0) at EX`LAT`;
  - `ex1_vld`=1 with `ex1_sel` not one-hot.
- `ex1_mfvr_data` is independent of `ex1_vld`. It is 0 when `ex1_sel`=0.

## Timing
- Reset (`cpurst_b`=0 at an edge) clears the following to 0: all tracked vld, `wb_vld`, `wb_tag`, `wb_data`, `wb_ereg`, `fflags`, `proto_err`.
- Reset asserted mid-operation discards every in-flight op with no writeback.
- Latency: an op issued in EX1 at cycle t samples unit outputs at cycle t+LAT-1. `wb_*` are valid at cycle t+LAT.
- Throughput: 1 op/cycle. Back-to-back ops with different units and tags write back in issue order, one per cycle.
- A `flush` at cycle f kills ops issued at cycles f-LAT+2..f. The op in EX`LAT` at cycle f still writes back at f+1.

## Structure
- Shared package (`ct_vfalu_pkg`) holds:
  - the EREG bit index constants (NV=4, DZ=3, OF=2, UF=1, NX=0);
  - the LAT/NUM_UNIT legality bounds;
  - the `onehot_chk` function.
- One natural sub-module, `ct_vfalu_onehot_mux` (params W, N): AND-OR select, instantiated for mfvr, result and ereg.

## Test plan
- Single op: reset, LAT=3, issue `ex1_sel`=3'b010, tag=7'h15; unit1 drives r_vld, result 64'hDEAD_BEEF_0000_0001, ereg 5'b00001 at cycle t+2 -> `wb_vld`=1, tag 7'h15, that data, `fflags`=5'b00001 at t+3.
- Back-to-back: issue to units 0, 1, 2 on consecutive cycles with distinct data -> three consecutive `wb_vld` pulses in order; `fflags` = OR of the three ereg values.
- Flush: issue at t and t+1; `flush` at t+1 with LAT=3 -> neither writes back; an op issued at t+2 writes back at t+5.
- Protocol: unit2 asserts `unit_r_vld` with no tracked op -> `proto_err`=1 and stays 1; `wb_vld` stays 0.
- Sticky clear: `fflags`=5'b10000; `fflags_clr` in the cycle a 5'b00100 writeback lands -> `fflags`=5'b00100.
- Parameter sweep: NUM_UNIT=5, LAT=6, DATA_W=32 -> latency exactly 6; `ex1_mfvr_data` follows `ex1_sel` combinationally; reset mid-stream -> all outputs 0, no stray writeback.

Source files
------------

// File: rtl/ct_vfalu_pkg.sv
// Shared constants and helpers for the VFALU result-collection pipe.
package ct_vfalu_pkg;

    // Exception flag bit positions inside an EREG word.
    localparam int EREG_NV = 4;
    localparam int EREG_DZ = 3;
    localparam int EREG_OF = 2;
    localparam int EREG_UF = 1;
    localparam int EREG_NX = 0;

    localparam int NUM_UNIT_MIN = 2;
    localparam int NUM_UNIT_MAX = 8;
    localparam int LAT_MIN      = 2;
    localparam int LAT_MAX      = 6;

    // Selects are at most NUM_UNIT_MAX bits wide; callers zero-extend to 8.
    function automatic logic onehot_chk(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

endpackage

// File: rtl/ct_vfalu_wb_pipe_gen_if.sv
// Bundle between the functional units / issue logic and the writeback pipe.
interface ct_vfalu_wb_pipe_gen_if #(
    parameter int DATA_W   = 64,
    parameter int EREG_W   = 5,
    parameter int NUM_UNIT = 3,
    parameter int TAG_W    = 7
) ();

    logic                         ex1_vld;
    logic [NUM_UNIT-1:0]          ex1_sel;
    logic [TAG_W-1:0]             ex1_tag;
    logic                         flush;
    logic [NUM_UNIT*DATA_W-1:0]   unit_mfvr_data;
    logic [NUM_UNIT-1:0]          unit_r_vld;
    logic [NUM_UNIT*DATA_W-1:0]   unit_result;
    logic [NUM_UNIT-1:0]          unit_ereg_vld;
    logic [NUM_UNIT*EREG_W-1:0]   unit_ereg;
    logic                         fflags_clr;

    logic [DATA_W-1:0]            ex1_mfvr_data;
    logic                         wb_vld;
    logic [TAG_W-1:0]             wb_tag;
    logic [DATA_W-1:0]            wb_data;
    logic [EREG_W-1:0]            wb_ereg;
    logic [EREG_W-1:0]            fflags;
    logic                         proto_err;

    modport master (
        output ex1_vld, ex1_sel, ex1_tag, flush, unit_mfvr_data, unit_r_vld,
               unit_result, unit_ereg_vld, unit_ereg, fflags_clr,
        input  ex1_mfvr_data, wb_vld, wb_tag, wb_data, wb_ereg, fflags, proto_err
    );

    modport slave (
        input  ex1_vld, ex1_sel, ex1_tag, flush, unit_mfvr_data, unit_r_vld,
               unit_result, unit_ereg_vld, unit_ereg, fflags_clr,
        output ex1_mfvr_data, wb_vld, wb_tag, wb_data, wb_ereg, fflags, proto_err
    );

endinterface

// File: rtl/ct_vfalu_onehot_mux.sv
// AND-OR selector: ORs every W-bit lane whose select bit is set (0 when no select).
module ct_vfalu_onehot_mux #(
    parameter int W = 64,
    parameter int N = 3
) (
    input  logic [N-1:0]   i_sel,
    input  logic [N*W-1:0] i_data,
    output logic [W-1:0]   o_data
);

    always_comb begin
        o_data = '0;
        for (int i = 0; i < N; i++) begin
            o_data = o_data | (i_data[i*W +: W] & {W{i_sel[i]}});
        end
    end

endmodule

// File: rtl/ct_vfalu_wb_pipe_gen.sv
// VFALU result-collection pipe: tracks issued ops to EX<LAT>, picks the owning unit's
// result and flags there, registers writeback and keeps sticky flags / protocol error.
module ct_vfalu_wb_pipe_gen
    import ct_vfalu_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int EREG_W   = 5,
    parameter int NUM_UNIT = 3,
    parameter int LAT      = 3,
    parameter int TAG_W    = 7
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    ct_vfalu_wb_pipe_gen_if.slave bus
);

    // Index 0 is EX2, index DEPTH-1 is the result stage EX<LAT>.
    localparam int DEPTH = LAT - 1;

    if (NUM_UNIT < NUM_UNIT_MIN || NUM_UNIT > NUM_UNIT_MAX) begin : g_bad_num_unit
        $error("ct_vfalu_wb_pipe_gen: NUM_UNIT out of range");
    end
    if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
        $error("ct_vfalu_wb_pipe_gen: LAT out of range");
    end

    logic [DEPTH-1:0]    r_trk_vld;
    logic [NUM_UNIT-1:0] r_trk_sel [DEPTH];
    logic [TAG_W-1:0]    r_trk_tag [DEPTH];

    logic                r_wb_vld;
    logic [TAG_W-1:0]    r_wb_tag;
    logic [DATA_W-1:0]   r_wb_data;
    logic [EREG_W-1:0]   r_wb_ereg;
    logic [EREG_W-1:0]   r_fflags;
    logic                r_proto_err;

    logic                w_res_vld;
    logic [NUM_UNIT-1:0] w_res_sel;
    logic [NUM_UNIT-1:0] w_ereg_sel;
    logic [DATA_W-1:0]   w_res_data;
    logic [EREG_W-1:0]   w_res_ereg;
    logic [DATA_W-1:0]   w_mfvr_data;
    logic                w_rvld_bad;
    logic                w_sel_bad;

    assign w_res_vld  = r_trk_vld[DEPTH-1];
    assign w_res_sel  = w_res_vld ? r_trk_sel[DEPTH-1] : '0;
    assign w_ereg_sel = w_res_sel & bus.unit_ereg_vld;
    assign w_rvld_bad = (bus.unit_r_vld != w_res_sel);
    assign w_sel_bad  = bus.ex1_vld & ~onehot_chk(8'(bus.ex1_sel));

    ct_vfalu_onehot_mux #(.W(DATA_W), .N(NUM_UNIT)) u_mux_mfvr (
        .i_sel  (bus.ex1_sel),
        .i_data (bus.unit_mfvr_data),
        .o_data (w_mfvr_data)
    );

    ct_vfalu_onehot_mux #(.W(DATA_W), .N(NUM_UNIT)) u_mux_result (
        .i_sel  (w_res_sel),
        .i_data (bus.unit_result),
        .o_data (w_res_data)
    );

    // Flags from a unit that does not flag them valid are dropped to zero.
    ct_vfalu_onehot_mux #(.W(EREG_W), .N(NUM_UNIT)) u_mux_ereg (
        .i_sel  (w_ereg_sel),
        .i_data (bus.unit_ereg),
        .o_data (w_res_ereg)
    );

    // A flush also drops the op sitting in EX1 this cycle.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_trk_vld <= '0;
        end else begin
            r_trk_vld[0] <= bus.ex1_vld & ~bus.flush;
            for (int k = 1; k < DEPTH; k++) begin
                r_trk_vld[k] <= r_trk_vld[k-1] & ~bus.flush;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        r_trk_sel[0] <= bus.ex1_sel;
        r_trk_tag[0] <= bus.ex1_tag;
        for (int k = 1; k < DEPTH; k++) begin
            r_trk_sel[k] <= r_trk_sel[k-1];
            r_trk_tag[k] <= r_trk_tag[k-1];
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_wb_vld    <= 1'b0;
            r_wb_tag    <= '0;
            r_wb_data   <= '0;
            r_wb_ereg   <= '0;
            r_fflags    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_wb_vld <= w_res_vld;
            if (w_res_vld) begin
                r_wb_tag  <= r_trk_tag[DEPTH-1];
                r_wb_data <= w_res_data;
                r_wb_ereg <= w_res_ereg;
            end
            // Clear wins over the old value but not over flags landing this cycle.
            r_fflags <= (bus.fflags_clr ? '0 : r_fflags) | w_res_ereg;
            if (w_rvld_bad || w_sel_bad) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign bus.ex1_mfvr_data = w_mfvr_data;
    assign bus.wb_vld        = r_wb_vld;
    assign bus.wb_tag        = r_wb_tag;
    assign bus.wb_data       = r_wb_data;
    assign bus.wb_ereg       = r_wb_ereg;
    assign bus.fflags        = r_fflags;
    assign bus.proto_err     = r_proto_err;

endmodule

// File: tb/tb_ct_vfalu_wb_pipe_gen.sv
// Bench for ct_vfalu_wb_pipe_gen: a default instance and a wide/deep one, each checked
// against an issue-cycle indexed model of the writeback pipe.
module tb_ct_vfalu_wb_pipe_gen;
    import ct_vfalu_pkg::*;

    localparam int A_DW  = 64;
    localparam int A_NU  = 3;
    localparam int A_LAT = 3;
    localparam int B_DW  = 32;
    localparam int B_NU  = 5;
    localparam int B_LAT = 6;
    localparam int EW    = 5;
    localparam int TW    = 7;
    localparam int MAXC  = 2048;

    localparam logic [EW-1:0] F_NV = EW'(1) << EREG_NV;
    localparam logic [EW-1:0] F_DZ = EW'(1) << EREG_DZ;
    localparam logic [EW-1:0] F_OF = EW'(1) << EREG_OF;
    localparam logic [EW-1:0] F_UF = EW'(1) << EREG_UF;
    localparam logic [EW-1:0] F_NX = EW'(1) << EREG_NX;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    ct_vfalu_wb_pipe_gen_if #(.DATA_W(A_DW), .EREG_W(EW), .NUM_UNIT(A_NU), .TAG_W(TW)) if_a ();
    ct_vfalu_wb_pipe_gen_if #(.DATA_W(B_DW), .EREG_W(EW), .NUM_UNIT(B_NU), .TAG_W(TW)) if_b ();

    ct_vfalu_wb_pipe_gen #(.DATA_W(A_DW), .EREG_W(EW), .NUM_UNIT(A_NU), .LAT(A_LAT), .TAG_W(TW)) u_dut_a (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_b),
        .bus            (if_a)
    );

    ct_vfalu_wb_pipe_gen #(.DATA_W(B_DW), .EREG_W(EW), .NUM_UNIT(B_NU), .LAT(B_LAT), .TAG_W(TW)) u_dut_b (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_b),
        .bus            (if_b)
    );

    // Stimulus is built once at full width and routed to the instance under test.
    int             cur;
    logic           d_vld, d_flush, d_clr;
    logic [7:0]     d_sel, d_rvld, d_evld;
    logic [TW-1:0]  d_tag;
    logic [63:0]    d_mfvr [8];
    logic [63:0]    d_res  [8];
    logic [EW-1:0]  d_ereg [8];

    assign if_a.ex1_vld       = (cur == 0) & d_vld;
    assign if_a.ex1_sel       = (cur == 0) ? d_sel[A_NU-1:0] : '0;
    assign if_a.ex1_tag       = d_tag;
    assign if_a.flush         = (cur == 0) & d_flush;
    assign if_a.fflags_clr    = (cur == 0) & d_clr;
    assign if_a.unit_r_vld    = (cur == 0) ? d_rvld[A_NU-1:0] : '0;
    assign if_a.unit_ereg_vld = d_evld[A_NU-1:0];
    for (genvar i = 0; i < A_NU; i++) begin : g_a
        assign if_a.unit_mfvr_data[i*A_DW +: A_DW] = d_mfvr[i][A_DW-1:0];
        assign if_a.unit_result[i*A_DW +: A_DW]    = d_res[i][A_DW-1:0];
        assign if_a.unit_ereg[i*EW +: EW]          = d_ereg[i];
    end

    assign if_b.ex1_vld       = (cur == 1) & d_vld;
    assign if_b.ex1_sel       = (cur == 1) ? d_sel[B_NU-1:0] : '0;
    assign if_b.ex1_tag       = d_tag;
    assign if_b.flush         = (cur == 1) & d_flush;
    assign if_b.fflags_clr    = (cur == 1) & d_clr;
    assign if_b.unit_r_vld    = (cur == 1) ? d_rvld[B_NU-1:0] : '0;
    assign if_b.unit_ereg_vld = d_evld[B_NU-1:0];
    for (genvar i = 0; i < B_NU; i++) begin : g_b
        assign if_b.unit_mfvr_data[i*B_DW +: B_DW] = d_mfvr[i][B_DW-1:0];
        assign if_b.unit_result[i*B_DW +: B_DW]    = d_res[i][B_DW-1:0];
        assign if_b.unit_ereg[i*EW +: EW]          = d_ereg[i];
    end

    logic           o_wbv, o_perr;
    logic [TW-1:0]  o_tag;
    logic [63:0]    o_data, o_mfvr;
    logic [EW-1:0]  o_ereg, o_ff;

    always_comb begin
        o_wbv  = if_a.wb_vld;
        o_perr = if_a.proto_err;
        o_tag  = if_a.wb_tag;
        o_data = if_a.wb_data;
        o_mfvr = if_a.ex1_mfvr_data;
        o_ereg = if_a.wb_ereg;
        o_ff   = if_a.fflags;
        if (cur == 1) begin
            o_wbv  = if_b.wb_vld;
            o_perr = if_b.proto_err;
            o_tag  = if_b.wb_tag;
            o_data = 64'(if_b.wb_data);
            o_mfvr = 64'(if_b.ex1_mfvr_data);
            o_ereg = if_b.wb_ereg;
            o_ff   = if_b.fflags;
        end
    end

    // Reference model: one record per issue cycle; an op's result is due LAT-1 cycles
    // after issue and its writeback is visible LAT cycles after issue.
    int             lat, nu, cyc, n_cmp, n_bad, lat_meas;
    logic [63:0]    dmask;
    bit             armed;
    bit             m_vld  [MAXC];
    bit             m_ev   [MAXC];
    logic [7:0]     m_sel  [MAXC];
    logic [TW-1:0]  m_tag  [MAXC];
    logic [63:0]    m_data [MAXC];
    logic [EW-1:0]  m_ereg [MAXC];
    bit             e_wbv, e_perr;
    logic [TW-1:0]  e_tag;
    logic [63:0]    e_data;
    logic [EW-1:0]  e_ereg, e_ff;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic use_inst(input int k);
        cur   = k;
        lat   = (k == 1) ? B_LAT : A_LAT;
        nu    = (k == 1) ? B_NU : A_NU;
        dmask = (k == 1) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        armed = 1'b0;
        for (int c = 0; c < MAXC; c++) m_vld[c] = 1'b0;
    endtask

    task automatic step(input bit rb, input bit vld, input logic [7:0] sel, input logic [TW-1:0] tag,
                        input bit fl, input bit clr, input logic [63:0] odata,
                        input logic [EW-1:0] oereg, input bit oev, input logic [7:0] bad);
        int r;
        bit alive;
        logic [EW-1:0] eff;
        logic [63:0] mexp;
        r = cyc - (lat - 1);
        alive = 1'b0;
        if (r >= 0) alive = m_vld[r];
        rst_b = rb; d_vld = vld; d_sel = sel; d_tag = tag; d_flush = fl; d_clr = clr;
        d_evld = 8'($urandom);
        for (int u = 0; u < 8; u++) begin
            d_mfvr[u] = {$urandom, $urandom};
            d_res[u]  = {$urandom, $urandom};
            d_ereg[u] = EW'($urandom);
        end
        d_rvld = bad;
        if (alive) begin
            d_rvld = m_sel[r] | bad;
            for (int u = 0; u < 8; u++) begin
                if (m_sel[r][u]) begin
                    d_res[u]  = m_data[r];
                    d_ereg[u] = m_ereg[r];
                    d_evld[u] = m_ev[r];
                end
            end
        end
        #1;
        if (sel == 8'h00 || $countones(sel) == 1) begin
            mexp = '0;
            for (int u = 0; u < nu; u++) if (sel[u]) mexp = d_mfvr[u] & dmask;
            check_val("mfvr", o_mfvr, mexp);
        end
        if (!rb) begin
            for (int c = cyc - lat + 1; c <= cyc; c++) if (c >= 0) m_vld[c] = 1'b0;
            e_wbv = 1'b0; e_tag = '0; e_data = '0; e_ereg = '0; e_ff = '0; e_perr = 1'b0;
            armed = 1'b1;
        end else begin
            m_vld[cyc]  = vld && !fl;
            m_sel[cyc]  = sel;
            m_tag[cyc]  = tag;
            m_data[cyc] = odata & dmask;
            m_ereg[cyc] = oereg;
            m_ev[cyc]   = oev;
            if (fl) for (int c = cyc - lat + 2; c < cyc; c++) if (c >= 0) m_vld[c] = 1'b0;
            eff = '0;
            if (alive && m_ev[r]) eff = m_ereg[r];
            e_wbv = alive;
            if (alive) begin
                e_tag  = m_tag[r];
                e_data = m_data[r];
                e_ereg = eff;
            end
            e_ff = (clr ? '0 : e_ff) | eff;
            if (bad != 8'h00 || (vld && $countones(sel) != 1)) e_perr = 1'b1;
        end
        @(negedge clk);
        cyc++;
        if (armed) begin
            check_val("wb_vld",    64'(o_wbv),  64'(e_wbv));
            check_val("wb_tag",    64'(o_tag),  64'(e_tag));
            check_val("wb_data",   o_data,      e_data);
            check_val("wb_ereg",   64'(o_ereg), 64'(e_ereg));
            check_val("fflags",    64'(o_ff),   64'(e_ff));
            check_val("proto_err", 64'(o_perr), 64'(e_perr));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, '0, 1'b0, 1'b0, '0, '0, 1'b0, 8'h00);
    endtask

    task automatic rnd_step(input int p_rst);
        bit rb, v;
        logic [7:0] s;
        rb = ($urandom_range(0, 99) >= p_rst);
        v  = ($urandom_range(0, 99) < 70);
        s  = 8'h00;
        if (v || $urandom_range(0, 1) == 1) s = 8'(1) << $urandom_range(0, nu - 1);
        step(rb, v, s, TW'($urandom), $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 8,
             {$urandom, $urandom}, EW'($urandom), 1'($urandom_range(0, 1)), 8'h00);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; lat_meas = 0;
        rst_b = 1'b0; d_vld = 1'b0; d_flush = 1'b0; d_clr = 1'b0;
        d_sel = '0; d_rvld = '0; d_evld = '0; d_tag = '0;
        e_wbv = 1'b0; e_perr = 1'b0; e_tag = '0; e_data = '0; e_ereg = '0; e_ff = '0;
        use_inst(0);
        step(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b0, '0, '0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b0, '0, '0, 1'b0, 8'h00);

        // single op to unit1
        step(1'b1, 1'b1, 8'b010, 7'h15, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_0001, F_NX, 1'b1, 8'h00);
        idle(2);
        check_val("single_vld",  64'(o_wbv), 64'd1);
        check_val("single_tag",  64'(o_tag), 64'h15);
        check_val("single_data", o_data,     64'hDEAD_BEEF_0000_0001);
        check_val("single_ff",   64'(o_ff),  64'(F_NX));

        // back-to-back to units 0,1,2 (clear sticky flags first cycle)
        step(1'b1, 1'b1, 8'b001, 7'h01, 1'b0, 1'b1, 64'h1111_0000_0000_0001, F_UF, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'b010, 7'h02, 1'b0, 1'b0, 64'h2222_0000_0000_0002, F_DZ, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'b100, 7'h03, 1'b0, 1'b0, 64'h3333_0000_0000_0003, F_NV, 1'b1, 8'h00);
        check_val("b2b_tag0", 64'(o_tag), 64'h01);
        idle(1);
        check_val("b2b_tag1", 64'(o_tag), 64'h02);
        idle(1);
        check_val("b2b_tag2", 64'(o_tag), 64'h03);
        check_val("b2b_data2", o_data, 64'h3333_0000_0000_0003);
        idle(1);
        check_val("b2b_idle", 64'(o_wbv), 64'd0);
        check_val("b2b_ff",   64'(o_ff),  64'(F_UF | F_DZ | F_NV));

        // flush at t+1 kills ops from t and t+1; op at t+2 writes back at t+5
        step(1'b1, 1'b1, 8'b001, 7'h10, 1'b0, 1'b0, 64'hAAAA, F_OF, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'b010, 7'h11, 1'b1, 1'b0, 64'hBBBB, F_OF, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'b100, 7'h33, 1'b0, 1'b0, 64'hCCCC, '0,   1'b1, 8'h00);
        check_val("flush_t3", 64'(o_wbv), 64'd0);
        idle(1);
        check_val("flush_t4", 64'(o_wbv), 64'd0);
        idle(1);
        check_val("flush_t5_vld", 64'(o_wbv), 64'd1);
        check_val("flush_t5_tag", 64'(o_tag), 64'h33);

        // sticky clear in the same cycle a new flag lands
        step(1'b1, 1'b1, 8'b001, 7'h20, 1'b0, 1'b1, 64'h1, F_NV, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'b010, 7'h21, 1'b0, 1'b0, 64'h2, F_OF, 1'b1, 8'h00);
        idle(1);
        check_val("sticky_pre", 64'(o_ff), 64'(F_NV));
        step(1'b1, 1'b0, 8'h00, '0, 1'b0, 1'b1, '0, '0, 1'b0, 8'h00);
        check_val("sticky_clr", 64'(o_ff), 64'(F_OF));

        for (int i = 0; i < 300; i++) rnd_step(1);

        // unit2 claims a result with nothing tracked
        idle(A_LAT);
        step(1'b1, 1'b0, 8'h00, '0, 1'b0, 1'b0, '0, '0, 1'b0, 8'b100);
        check_val("proto_set", 64'(o_perr), 64'd1);
        check_val("proto_nowb", 64'(o_wbv), 64'd0);
        idle(3);
        check_val("proto_sticky", 64'(o_perr), 64'd1);
        step(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b0, '0, '0, 1'b0, 8'h00);
        check_val("proto_rst", 64'(o_perr), 64'd0);
        step(1'b1, 1'b1, 8'b011, 7'h44, 1'b1, 1'b0, '0, '0, 1'b0, 8'h00);
        check_val("proto_sel", 64'(o_perr), 64'd1);

        // wide/deep instance
        use_inst(1);
        step(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b0, '0, '0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b0, '0, '0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h10, 7'h2A, 1'b0, 1'b0, 64'h0000_0000_C0DE_F00D, F_DZ | F_NX, 1'b1, 8'h00);
        for (int k = 1; k <= 20; k++) begin
            if (o_wbv) begin
                lat_meas = k;
                break;
            end
            idle(1);
        end
        check_val("b_latency", 64'(lat_meas), 64'(B_LAT));
        check_val("b_tag", 64'(o_tag), 64'h2A);
        check_val("b_data", o_data, 64'h0000_0000_C0DE_F00D);

        for (int i = 0; i < 4; i++) rnd_step(0);
        step(1'b0, 1'b1, 8'h01, 7'h55, 1'b0, 1'b0, '0, '0, 1'b0, 8'h00);
        check_val("b_rst_vld",  64'(o_wbv),  64'd0);
        check_val("b_rst_data", o_data,      64'd0);
        check_val("b_rst_tag",  64'(o_tag),  64'd0);
        check_val("b_rst_ff",   64'(o_ff),   64'd0);
        idle(B_LAT + 2);

        for (int i = 0; i < 300; i++) rnd_step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
